// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator car controller.
// Pure declarations; no latency, no flow control.
package elevator_pkg;
  localparam int NUM_FLOORS = 8;
  localparam int FLOOR_W    = 3;

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_e;

  localparam int CLR_INSIDE = 2;
  localparam int CLR_UP     = 1;
  localparam int CLR_DOWN   = 0;

  // True when any request lies strictly above (up=1) or below (up=0) floor f.
  function automatic logic any_beyond(input logic [NUM_FLOORS-1:0] req,
                                      input logic [FLOOR_W-1:0]    f,
                                      input logic                  up);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if ((up && i > int'(f)) || (!up && i < int'(f))) r = r | req[i];
    end
    return r;
  endfunction
endpackage

// File: rtl/elevator_scheduler_if.sv
// Call vectors in, car commands and clear strobes out; estop exists only with ELEV_ESTOP_EN.
// master = car controller, slave = floor-call register file side; no backpressure.
interface elevator_scheduler_if;
  import elevator_pkg::*;

  logic [NUM_FLOORS-1:0] call_inside;
  logic [NUM_FLOORS-1:0] call_up;
  logic [NUM_FLOORS-1:0] call_down;
`ifdef ELEV_ESTOP_EN
  logic                  estop;
`endif
  logic [FLOOR_W-1:0]    floor;
  logic                  moving_up;
  logic                  moving_down;
  logic                  door_open;
  logic                  clr_valid;
  logic [FLOOR_W-1:0]    clr_floor;
  logic [2:0]            clr_mask;

  modport master (
`ifdef ELEV_ESTOP_EN
    input  estop,
`endif
    input  call_inside, call_up, call_down,
    output floor, moving_up, moving_down, door_open, clr_valid, clr_floor, clr_mask
  );

  modport slave (
`ifdef ELEV_ESTOP_EN
    output estop,
`endif
    output call_inside, call_up, call_down,
    input  floor, moving_up, moving_down, door_open, clr_valid, clr_floor, clr_mask
  );
endinterface

// File: rtl/elevator_scheduler_timer.sv
// Loadable down-counter shared by travel and door phases; done while count is zero.
// load takes effect on the next edge; hold freezes the count.
module cycle_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         hold,
  output logic         done
);
  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (!hold) begin
      if (load) count_q <= load_val;
      else if (count_q != '0) count_q <= count_q - 1'b1;
    end
  end

  assign done = (count_q == '0);
endmodule

// File: rtl/elevator_scheduler.sv
// SCAN car controller: one-cycle decisions, registered outputs, one clear strobe per door opening.
// Optional emergency stop under ELEV_ESTOP_EN freezes state and timer; no backpressure on calls.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  elevator_scheduler_if.master bus
);
  localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW      = $clog2(MAX_CYC);

  state_e               state_q, state_d;
  logic [FLOOR_W-1:0]   floor_q, floor_d, step_floor, arr_floor, clr_floor_q;
  logic                 dir_q, dir_d;
  logic                 moving_up_q, moving_down_q, door_open_q, clr_valid_q;
  logic [2:0]           clr_mask_q, entry_mask, restart_mask;
  logic [NUM_FLOORS-1:0] req;
  logic                 above, below, ahead, at_inside, at_dir, at_opp, reverse, stop_here;
  logic                 idle_door, idle_up, idle_down, step, enter_door, door_restart, door_close;
  logic                 halt, tmr_load, tmr_done;
  logic [TW-1:0]        tmr_val;

`ifdef ELEV_ESTOP_EN
  assign halt = bus.estop;
`else
  assign halt = 1'b0;
`endif

  always_comb begin
    req   = bus.call_inside | bus.call_up | bus.call_down;
    above = any_beyond(req, floor_q, 1'b1);
    below = any_beyond(req, floor_q, 1'b0);
    if (dir_q && floor_q != FLOOR_W'(NUM_FLOORS - 1)) step_floor = floor_q + 1'b1;
    else if (!dir_q && floor_q != '0)                 step_floor = floor_q - 1'b1;
    else                                              step_floor = floor_q;
    // Floor the door would open at: the next floor while travelling, else here.
    arr_floor = (state_q == MOVE) ? step_floor : floor_q;
    ahead     = any_beyond(req, arr_floor, dir_q);
    at_inside = bus.call_inside[arr_floor];
    at_dir    = dir_q ? bus.call_up[arr_floor]   : bus.call_down[arr_floor];
    at_opp    = dir_q ? bus.call_down[arr_floor] : bus.call_up[arr_floor];
    // Also reverse when only the opposite hall call is here, so it gets served and cleared.
    reverse   = !ahead || !(at_inside || at_dir);
    stop_here = at_inside || at_dir || (!ahead && req[arr_floor]);

    entry_mask             = '0;
    entry_mask[CLR_INSIDE] = at_inside;
    entry_mask[CLR_UP]     = dir_q ? at_dir : (reverse & at_opp);
    entry_mask[CLR_DOWN]   = dir_q ? (reverse & at_opp) : at_dir;

    restart_mask             = '0;
    restart_mask[CLR_INSIDE] = bus.call_inside[floor_q];
    restart_mask[CLR_UP]     = dir_q & bus.call_up[floor_q];
    restart_mask[CLR_DOWN]   = !dir_q & bus.call_down[floor_q];

    idle_door    = (state_q == IDLE) && req[floor_q];
    idle_up      = (state_q == IDLE) && !req[floor_q] && above && (dir_q || !below);
    idle_down    = (state_q == IDLE) && !req[floor_q] && !idle_up && below;
    step         = (state_q == MOVE) && tmr_done;
    enter_door   = idle_door || (step && stop_here);
    // The cycle after a strobe still shows the call being cleared; ignore it then.
    door_restart = (state_q == DOOR) && !clr_valid_q && (restart_mask != '0);
    door_close   = (state_q == DOOR) && tmr_done && !door_restart;

    state_d = state_q;
    dir_d   = dir_q;
    floor_d = floor_q;
    if (enter_door) begin
      state_d = DOOR;
      floor_d = arr_floor;
      dir_d   = reverse ? !dir_q : dir_q;
    end else if (idle_up || idle_down) begin
      state_d = MOVE;
      dir_d   = idle_up;
    end else if (step) begin
      floor_d = arr_floor;
      state_d = ahead ? MOVE : IDLE;
    end else if (door_close) begin
      state_d = IDLE;
    end

    tmr_load = !halt && (enter_door || door_restart || idle_up || idle_down || (step && ahead));
    tmr_val  = (enter_door || door_restart) ? TW'(DOOR_CYCLES - 1) : TW'(TRAVEL_CYCLES - 1);
  end

  cycle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .hold     (halt),
    .done     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      floor_q       <= '0;
      dir_q         <= 1'b1;
      moving_up_q   <= 1'b0;
      moving_down_q <= 1'b0;
      door_open_q   <= 1'b0;
      clr_valid_q   <= 1'b0;
      clr_floor_q   <= '0;
      clr_mask_q    <= '0;
    end else if (halt) begin
      moving_up_q   <= 1'b0;
      moving_down_q <= 1'b0;
      door_open_q   <= 1'b0;
      clr_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      floor_q       <= floor_d;
      dir_q         <= dir_d;
      moving_up_q   <= (state_d == MOVE) && dir_d;
      moving_down_q <= (state_d == MOVE) && !dir_d;
      door_open_q   <= (state_d == DOOR);
      clr_valid_q   <= enter_door || door_restart;
      if (enter_door) begin
        clr_floor_q <= arr_floor;
        clr_mask_q  <= entry_mask;
      end else if (door_restart) begin
        clr_floor_q <= floor_q;
        clr_mask_q  <= restart_mask;
      end
    end
  end

  assign bus.floor       = floor_q;
  assign bus.moving_up   = moving_up_q;
  assign bus.moving_down = moving_down_q;
  assign bus.door_open   = door_open_q;
  assign bus.clr_valid   = clr_valid_q;
  assign bus.clr_floor   = clr_floor_q;
  assign bus.clr_mask    = clr_mask_q;
endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed scenarios plus random calls against a lockstep model.
// The bench plays the call register file, dropping calls on each expected clear strobe.
module tb_elevator_scheduler;
  localparam int T = 16;
  localparam int D = 32;
  localparam int M_IDLE = 0, M_MOVE = 1, M_DOOR = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  elevator_scheduler_if bus();
  elevator_scheduler #(.TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fails  = 0;

  bit [7:0] ci_v, cu_v, cd_v;
  bit       rst_v, estop_v, rnd_en;

  // model: whole-car view in plain integers
  int m_mode, m_floor, m_dir, m_left;
  bit m_fresh;
  bit e_mu, e_md, e_door, e_cv;
  bit [2:0] e_cf, e_cm;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      if (n_fails >= 40) begin
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
      end
    end
  endtask

  function automatic bit pend(int f);
    return ci_v[f] | cu_v[f] | cd_v[f];
  endfunction

  function automatic int count_ahead(int f, int d);
    int n = 0;
    for (int i = 0; i < 8; i++)
      if (((d > 0 && i > f) || (d < 0 && i < f)) && pend(i)) n++;
    return n;
  endfunction

  function automatic bit hall_with(int f, int d);
    return (d > 0) ? cu_v[f] : cd_v[f];
  endfunction

  task automatic arrive(int f);
    bit ins, hd, ho, rev;
    ins = ci_v[f];
    hd  = hall_with(f, m_dir);
    ho  = hall_with(f, -m_dir);
    rev = (count_ahead(f, m_dir) == 0) || !(ins || hd);
    e_cm = {ins, (m_dir > 0) ? hd : (rev & ho), (m_dir > 0) ? (rev & ho) : hd};
    e_cf = 3'(f);
    e_cv = 1;
    if (rev) m_dir = -m_dir;
    m_floor = f;
    m_mode = M_DOOR;
    m_left = D;
    m_fresh = 1;
  endtask

  task automatic model_step();
    int nf;
    bit stop, restart;
    e_cv = 0;
    if (rst_v) begin
      m_mode = M_IDLE; m_floor = 0; m_dir = 1; m_left = 0; m_fresh = 0;
      e_cf = 0; e_cm = 0;
    end else if (estop_v) begin
      m_fresh = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (pend(m_floor)) arrive(m_floor);
          else if (count_ahead(m_floor, 1) > 0 && (m_dir > 0 || count_ahead(m_floor, -1) == 0)) begin
            m_mode = M_MOVE; m_dir = 1; m_left = T;
          end else if (count_ahead(m_floor, -1) > 0) begin
            m_mode = M_MOVE; m_dir = -1; m_left = T;
          end
        end
        M_MOVE: begin
          m_left--;
          if (m_left == 0) begin
            nf = m_floor + m_dir;
            if (nf < 0 || nf > 7) nf = m_floor;
            m_floor = nf;
            stop = ci_v[nf] || hall_with(nf, m_dir) || (count_ahead(nf, m_dir) == 0 && pend(nf));
            if (stop) arrive(nf);
            else if (count_ahead(nf, m_dir) > 0) m_left = T;
            else m_mode = M_IDLE;
          end
        end
        default: begin
          restart = !m_fresh && (ci_v[m_floor] || hall_with(m_floor, m_dir));
          m_fresh = 0;
          if (restart) begin
            e_cv = 1; e_cf = 3'(m_floor);
            e_cm = {ci_v[m_floor], (m_dir > 0) & cu_v[m_floor], (m_dir < 0) & cd_v[m_floor]};
            m_left = D; m_fresh = 1;
          end else begin
            m_left--;
            if (m_left == 0) m_mode = M_IDLE;
          end
        end
      endcase
    end
    e_mu   = !rst_v && !estop_v && m_mode == M_MOVE && m_dir > 0;
    e_md   = !rst_v && !estop_v && m_mode == M_MOVE && m_dir < 0;
    e_door = !rst_v && !estop_v && m_mode == M_DOOR;
  endtask

  task automatic drive();
    reset = rst_v;
    bus.call_inside = ci_v;
    bus.call_up     = cu_v;
    bus.call_down   = cd_v;
`ifdef ELEV_ESTOP_EN
    bus.estop = estop_v;
`endif
  endtask

  task automatic random_call();
    int f, k;
    if ($urandom_range(0, 29) == 0) begin
      f = $urandom_range(0, 7);
      k = $urandom_range(0, 2);
      if (k == 0) ci_v[f] = 1;
      else if (k == 1 && f != 7) cu_v[f] = 1;
      else if (k == 2 && f != 0) cd_v[f] = 1;
    end
`ifdef ELEV_ESTOP_EN
    if (!estop_v && $urandom_range(0, 299) == 0) estop_v = 1;
    else if (estop_v && $urandom_range(0, 7) == 0) estop_v = 0;
`endif
  endtask

  task automatic tick();
    logic [12:0] got, exp;
    drive();
    model_step();
    @(posedge clk);
    #1;
    got = {bus.floor, bus.moving_up, bus.moving_down, bus.door_open, bus.clr_valid,
           bus.clr_valid ? bus.clr_floor : 3'd0, bus.clr_valid ? bus.clr_mask : 3'd0};
    exp = {3'(m_floor), e_mu, e_md, e_door, e_cv, e_cv ? e_cf : 3'd0, e_cv ? e_cm : 3'd0};
    check_eq("cycle_outputs", got, exp);
    if (e_cv) begin
      if (e_cm[2]) ci_v[e_cf] = 0;
      if (e_cm[1]) cu_v[e_cf] = 0;
      if (e_cm[0]) cd_v[e_cf] = 0;
    end
    if (rnd_en) random_call();
  endtask

  task automatic wait_strobe(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.clr_valid && n < max);
    if (!bus.clr_valid) n = -1;
  endtask

  task automatic do_reset();
    rst_v = 1; ci_v = 0; cu_v = 0; cd_v = 0; estop_v = 0;
    tick();
    tick();
    rst_v = 0;
  endtask

  initial begin
    int n;
    rnd_en = 0;
    do_reset();
    check_eq("reset_outputs", {bus.floor, bus.moving_up, bus.moving_down, bus.door_open, bus.clr_valid}, 0);
    check_eq("reset_clr_fields", {bus.clr_floor, bus.clr_mask}, 0);

    // inside call to floor 5 from reset
    ci_v[5] = 1;
    wait_strobe(200, n);
    check_eq("t1_arrival_cycles", n, 1 + 5 * T);
    check_eq("t1_clr_floor", bus.clr_floor, 5);
    check_eq("t1_clr_mask", bus.clr_mask, 3'b100);
    n = 0;
    while (bus.door_open && n < 100) begin n++; tick(); end
    check_eq("t1_door_cycles", n, D);

    // hall up at 2, hall down at 3
    do_reset();
    cu_v[2] = 1; cd_v[3] = 1;
    wait_strobe(200, n);
    check_eq("t2_first_floor", bus.clr_floor, 2);
    check_eq("t2_first_mask", bus.clr_mask, 3'b010);
    wait_strobe(200, n);
    check_eq("t2_second_floor", bus.clr_floor, 3);
    check_eq("t2_second_mask", bus.clr_mask, 3'b001);

    // down call raised at 4 while heading up to 6
    do_reset();
    ci_v[6] = 1;
    n = 0;
    while (bus.floor != 2 && n < 100) begin n++; tick(); end
    check_eq("t3_reach_2_timeout", n >= 100, 0);
    cd_v[4] = 1;
    wait_strobe(200, n);
    check_eq("t3_first_floor", bus.clr_floor, 6);
    check_eq("t3_first_mask", bus.clr_mask, 3'b100);
    wait_strobe(200, n);
    check_eq("t3_second_floor", bus.clr_floor, 4);
    check_eq("t3_second_mask", bus.clr_mask, 3'b001);

    // call at current floor while idle, then a repeat call during the door phase
    n = 0;
    while (bus.door_open && n < 100) begin n++; tick(); end
    ci_v[4] = 1;
    tick();
    check_eq("t4_door_no_motor", {bus.door_open, bus.moving_up, bus.moving_down, bus.clr_valid}, 4'b1001);
    repeat (10) tick();
    ci_v[4] = 1;
    tick();
    check_eq("t4_restart_strobe", {bus.clr_valid, bus.clr_floor}, {1'b1, 3'd4});
    n = 1;
    while (bus.door_open && n < 100) begin n++; tick(); end
    check_eq("t4_restart_door_cycles", n, D + 1);

    // reset while travelling
    do_reset();
    ci_v[7] = 1;
    n = 0;
    while (bus.floor != 3 && n < 200) begin n++; tick(); end
    check_eq("t5_reach_3_timeout", n >= 200, 0);
    repeat (5) tick();
    rst_v = 1;
    ci_v = 0;
    tick();
    check_eq("t5_reset_mid_move", {bus.floor, bus.moving_up, bus.moving_down, bus.door_open}, 0);
    rst_v = 0;

`ifdef ELEV_ESTOP_EN
    do_reset();
    ci_v[2] = 1;
    repeat (5) tick();
    estop_v = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("estop_no_clr", bus.clr_valid, 0);
    end
    estop_v = 0;
    wait_strobe(200, n);
    check_eq("estop_delayed_arrival", 15 + n, 1 + 2 * T + 10);
`endif

    // random calls against the model
    do_reset();
    rnd_en = 1;
    repeat (4000) tick();
    rnd_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Car controller for the eight-floor elevator. Consumes the `call_inside`/`call_up`/`call_down` vectors produced by the floor-call register file. Moves the car one floor at a time using a collective (SCAN) policy and opens the door at serviced floors. Emits one-cycle clear strobes so the register file can drop serviced calls.

## Interface
Parameters:
- `TRAVEL_CYCLES`, 16 — clock cycles to travel one floor (≥2).
- `DOOR_CYCLES`, 32 — clock cycles the door stays open (≥2).

Ports:
- `clk`  in  1  — sole clock, rising edge.
- `reset`  in  1  — synchronous, active-high.
- `call_inside`  in  8  — car-panel calls; bit n = floor n, MSB = top floor.
- `call_up`  in  8  — hall up-calls.
- `call_down`  in  8  — hall down-calls.
- `estop`  in  1  — emergency stop; present only with `ELEV_ESTOP_EN`.
- `floor`  out  3  — current car floor.
- `moving_up`, `moving_down`  out  1  — motor commands; never both high.
- `door_open`  out  1  — door command.
- `clr_valid`  out  1  — one-cycle clear strobe.
- `clr_floor`  out  3  — floor being cleared.
- `clr_mask`  out  3  — {inside, up, down} call types cleared.

## Operation
- Pending set: `req = call_inside | call_up | call_down`.
  - `above` = any `req` bit > `floor`.
  - `below` = any `req` bit < `floor`.
- `dir` register holds the sweep direction (1 = up). Resets to up.
- States: IDLE, MOVE, DOOR.
- **IDLE**
  - If `req[floor]` is set → DOOR.
  - Else if `above` and (`dir` = up or not `below`) → MOVE, `dir` = up.
  - Else if `below` → MOVE, `dir` = down.
  - Otherwise stay in IDLE.
- **MOVE**
  - Drive `moving_up`/`moving_down` per `dir`.
  - After `TRAVEL_CYCLES`, increment or decrement `floor`, then evaluate the stop rule at the new floor.
  - Stop if any of:
    - `call_inside[f]` is set.
    - The hall call in `dir` is set at f.
    - No requests remain ahead in `dir` and `req[f]` is set.
  - If stopping → DOOR. Otherwise stay in MOVE.
  - If nothing is ahead and nothing is at f → IDLE.
  - `floor` saturates at 0 and 7: reaching an end floor forces a stop or IDLE, never further travel.
- **DOOR**
  - On entry, assert `clr_valid` for one cycle with `clr_floor` = `floor`.
  - `clr_mask` = inside bit, plus the hall bit for `dir`.
  - Also clear the opposite hall bit when nothing is ahead in `dir`; `dir` reverses in that case.
  - `door_open` stays high for `DOOR_CYCLES` cycles, then → IDLE.
  - If a new call at `floor` matching `dir` arrives while open: restart the timer and issue another clear strobe.
- **Reset mid-operation:** aborts the current state and returns to IDLE, floor 0, dir up. All outputs go to 0 in the cycle after reset is sampled.

## Timing
- Reset values:
  - `floor` = 0.
  - `moving_up`, `moving_down`, `door_open`, `clr_valid` = 0.
  - `clr_floor` = 0, `clr_mask` = 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Call inputs are sampled each cycle; a decision uses values present in the cycle before the transition.
- IDLE→MOVE/DOOR latency: 1 cycle after the call is visible.
- Floor step: `floor` changes exactly `TRAVEL_CYCLES` cycles after entering MOVE or after the previous step.
- `door_open` rises in the same cycle as `clr_valid`. It is high for exactly `DOOR_CYCLES` cycles unless the timer is restarted.
- Simultaneous calls above and below in IDLE: the current `dir` wins.

## Configuration
- `ELEV_ESTOP_EN` defined:
  - The `estop` port exists.
  - While `estop` = 1, from any state: motor outputs drop the next cycle, the travel timer freezes, and `door_open` is forced 0.
  - Release resumes the frozen state with the remaining count.
  - `clr_valid` is suppressed during estop.
- `ELEV_ESTOP_EN` undefined: no `estop` port; the behaviour above is absent.

## Structure
- Package `elevator_pkg`:
  - `NUM_FLOORS` = 8 and `FLOOR_W` = 3.
  - State enum (IDLE, MOVE, DOOR).
  - `clr_mask` bit-position constants (INSIDE = 2, UP = 1, DOWN = 0).
- Sub-module `cycle_timer`: loadable down-counter with `load`, `hold`, and `done`. It is shared by the travel and door phases because they never overlap.

## Test plan
- Reset, then `call_inside` = 8'h20 → car reaches floor 5 after 5×16 cycles. Door opens with `clr_floor` = 5 and `clr_mask` = 3'b100, closes after 32 cycles, then IDLE.
- Car at 0, `call_up` = 8'h04 and `call_down` = 8'h08 → stops at 2 with mask 3'b010, then at 3 with mask 3'b001 and `dir` reversing.
- Car moving up from 2 to 6, `call_down[4]` raised en route → passes 4 without stopping and serves 6. Car reverses and stops at 4 on the way down.
- Call at the current floor in IDLE → `door_open` one cycle later with no motor pulse. A repeat call during DOOR restarts the 32-cycle timer.
- Reset asserted mid-MOVE at floor 3 → next cycle `floor` = 0, motors 0, state IDLE.
- With `ELEV_ESTOP_EN`: `estop` pulsed 10 cycles mid-travel → arrival delayed by exactly 10 cycles, no `clr_valid` during the pulse.
